// File: rtl/rf_scan_reader.sv
// rtl/rf_scan_reader.sv - register-file scan reader streaming registers as beats
//
// Purpose: on a start pulse, reads register-file entries FIRST_REG..LAST_REG
// one at a time through rf_addr/rf_data and streams each byte out with a
// valid/ready handshake, then pulses done. All outputs are registered.
//
// Optional feature: define RF_SCAN_CHECKSUM_EN to append one extra beat
// carrying the modulo-256 sum of all bytes emitted in the scan.
//
// Ports:
//   CLK        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   scan request pulse, honoured only while idle
//   rf_addr    out  [2:0] register-file read address (0 outside READ)
//   rf_data    in   [7:0] combinational register-file read data
//   out_data   out  [7:0] streamed byte
//   out_valid  out  out_data holds a valid beat
//   out_ready  in   downstream accepts the beat
//   busy       out  high whenever a scan is in progress
//   done       out  one-cycle pulse at scan completion
`timescale 1ns/1ps
module rf_scan_reader #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 7
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] rf_addr,
  input  logic [7:0] rf_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] FIRST_IDX = 3'(FIRST_REG);
  localparam logic [2:0] LAST_IDX  = 3'(LAST_REG);

`ifdef RF_SCAN_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

  state_t     state;
  logic [2:0] idx;

  // rf_addr is registered, so it is loaded with the index on the edge that
  // enters READ and cleared on the edge that leaves it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      rf_addr   <= 3'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef RF_SCAN_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= FIRST_IDX;
            rf_addr <= FIRST_IDX;
            busy    <= 1'b1;
            state   <= READ;
`ifdef RF_SCAN_CHECKSUM_EN
            csum    <= 8'h00;
`endif
          end
        end

        READ: begin
          out_data  <= rf_data;
          out_valid <= 1'b1;
          rf_addr   <= 3'd0;
          state     <= SEND;
`ifdef RF_SCAN_CHECKSUM_EN
          csum      <= csum + rf_data;
`endif
        end

        SEND: begin
          if (out_ready) begin
            if (idx != LAST_IDX) begin
              // idx never exceeds LAST_IDX (<= 7), so this cannot wrap.
              idx       <= idx + 3'd1;
              rf_addr   <= idx + 3'd1;
              out_valid <= 1'b0;
              state     <= READ;
            end else begin
`ifdef RF_SCAN_CHECKSUM_EN
              // csum already includes the last byte, captured in READ;
              // out_valid stays high for the back-to-back checksum beat.
              out_data  <= csum;
              state     <= CSUM;
`else
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end
          end
        end

`ifdef RF_SCAN_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_scan_reader.sv
// tb/tb_rf_scan_reader.sv - directed self-checking bench for rf_scan_reader
`timescale 1ns/1ps
module tb_rf_scan_reader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start2, out_ready, out_ready2;
  logic [2:0] rf_addr, rf_addr2;
  logic [7:0] rf_data, rf_data2, out_data, out_data2;
  logic       out_valid, out_valid2, busy, busy2, done, done2;

  logic [7:0] regs  [8];
  logic [7:0] regs2 [8];
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;

  // Register file with write-through forwarding; r0 is hard-wired to zero.
  always_comb begin
    rf_data = regs[rf_addr];
    if (we && wa == rf_addr && wa != 3'd0) rf_data = wd;
  end
  assign rf_data2 = regs2[rf_addr2];

  rf_scan_reader u_dut (
    .CLK(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  rf_scan_reader #(.FIRST_REG(3), .LAST_REG(3)) u_dut3 (
    .CLK(clk), .reset(reset), .start(start2), .rf_addr(rf_addr2), .rf_data(rf_data2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .busy(busy2), .done(done2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat/done log, sampled at the clock edge where the handshake happens.
  int         cyc = 0;
  logic [7:0] beats [$];
  int         beat_cyc [$];
  int         done_cnt, done_cyc, start_cyc;
  logic [7:0] beats2 [$];
  int         beat2_cyc [$];
  int         done2_cnt, done2_cyc, start2_cyc, addr3_cnt, addr3_cyc;

  always @(posedge clk) begin
    if (out_valid && out_ready) begin beats.push_back(out_data); beat_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (start && !busy && !reset) start_cyc = cyc;
    if (out_valid2 && out_ready2) begin beats2.push_back(out_data2); beat2_cyc.push_back(cyc); end
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    if (start2 && !busy2 && !reset) start2_cyc = cyc;
    if (rf_addr2 == 3'd3) begin addr3_cnt++; addr3_cyc = cyc; end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    beats.delete(); beat_cyc.delete(); done_cnt = 0; done_cyc = -1; start_cyc = -1;
    beats2.delete(); beat2_cyc.delete(); done2_cnt = 0; done2_cyc = -1; start2_cyc = -1;
    addr3_cnt = 0; addr3_cyc = -1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] exp_q [$];

  task automatic build_exp(input logic [7:0] first_byte);
    logic [7:0] sum;
    exp_q.delete();
    exp_q.push_back(first_byte);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    sum = 8'h00;
    foreach (exp_q[i]) sum = sum + exp_q[i];
`ifdef RF_SCAN_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic wait_beat(input logic [7:0] d);
    int n = 0;
    while (!(out_valid && out_data == d) && n < 100) begin tick(); n++; end
    check($sformatf("wait_beat_%0h", d), {31'd0, out_valid && out_data == d}, 32'd1);
  endtask

  task automatic wait_done;
    int n = 0;
    while (done_cnt < 1 && n < 200) begin tick(); n++; end
    check("done_seen", done_cnt, 1);
    repeat (4) tick();
  endtask

  task automatic check_scan(input string tag, input bit timing);
    check({tag, "_beats"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), beats[i], exp_q[i]);
      if (timing && i < 7)
        check($sformatf("%s_cyc%0d", tag, i), beat_cyc[i] - start_cyc, 2 + 2 * i);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    if (beat_cyc.size() > 0)
      check({tag, "_done_cyc"}, done_cyc - beat_cyc[beat_cyc.size() - 1], 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    we = 1'b0; wa = 3'd0; wd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      regs[i]  = 8'(i * 8'h11);
      regs2[i] = 8'h00;
    end
    regs2[3] = 8'hA5;
    clear_log();
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_out_data", out_data, 8'h00);
    reset = 1'b0;
    tick();

    // Basic scan, out_ready held high.
    clear_log(); build_exp(8'h11);
    pulse_start();
    check("read_rf_addr", rf_addr, 3'd1);
    wait_done();
    check_scan("basic", 1);

    // Stall the second beat for three cycles.
    clear_log(); build_exp(8'h11);
    pulse_start();
    wait_beat(8'h22);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_valid%0d", i), out_valid, 1);
      check($sformatf("stall_data%0d", i), out_data, 8'h22);
      check($sformatf("stall_addr%0d", i), rf_addr, 3'd0);
    end
    out_ready = 1'b1;
    wait_done();
    check_scan("stall", 0);

    // Start while busy is ignored and not queued.
    clear_log(); build_exp(8'h11);
    pulse_start();
    wait_beat(8'h33);
    pulse_start();
    wait_done();
    check_scan("busy_start", 1);
    repeat (6) tick();
    check("busy_start_idle", busy, 0);
    check("busy_start_done_cnt", done_cnt, 1);

    // Reset during a stalled 0x44 beat aborts the scan; reset beats start.
    clear_log();
    pulse_start();
    wait_beat(8'h44);
    out_ready = 1'b0;
    tick();
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (20) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_beats", beats.size(), 3);
    check("abort_still_idle", busy, 0);
    clear_log(); build_exp(8'h11);
    pulse_start();
    wait_done();
    check_scan("restart", 1);

    // Write to r1 in the READ cycle is captured through forwarding.
    clear_log(); build_exp(8'h5A);
    pulse_start();
    we = 1'b1; wa = 3'd1; wd = 8'h5A;
    tick();
    regs[1] = 8'h5A; we = 1'b0;
    wait_done();
    check_scan("fwd", 1);

    // Single-register scan on the FIRST_REG=LAST_REG=3 instance.
    clear_log();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (10) tick();
`ifdef RF_SCAN_CHECKSUM_EN
    check("single_beats", beats2.size(), 2);
`else
    check("single_beats", beats2.size(), 1);
`endif
    if (beats2.size() > 0) begin
      check("single_data", beats2[0], 8'hA5);
      check("single_cyc", beat2_cyc[0] - start2_cyc, 2);
      check("single_done_cyc", done2_cyc - beat2_cyc[beat2_cyc.size() - 1], 1);
    end
    check("single_done_cnt", done2_cnt, 1);
    check("single_addr3_cnt", addr3_cnt, 1);
    check("single_addr3_cyc", addr3_cyc - start2_cyc, 1);
    check("single_busy_end", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
